// File: rtl/core_pkg.sv
// core_pkg: shared fetch-stage types and defaults (state enum, XLEN/RESET_PC defaults, instruction size)
package core_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, TRAP} state_e;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int INSN_BYTES = 4;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC select (Jalr > Jump > Cnd > pc+4) and misaligned-target detect
//   in:  pc, imm, rs1_val, jalr, jump, cnd
//   out: target (selected next PC), misaligned (target[1] set)
module next_pc_calc
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            jalr,
  input  logic            jump,
  input  logic            cnd,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum   = rs1_val + imm;
  assign target     = jalr ? {jalr_sum[XLEN-1:1], 1'b0} :
                      (jump | cnd) ? pc + imm : pc + XLEN'(INSN_BYTES);
  assign misaligned = target[1];
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC, fetch request (valid/ready) and misaligned-target trap
//   in:  clk, rst, Cnd, Jump, Jalr, imm, rs1_val, instr_done, trap_clear, if_req_ready
//   out: if_req_valid, if_addr, pc, pc_plus4, misalign, bad_target, taken_cnt, instret_cnt
//   PC_FETCH_PERF_EN: builds the taken/instret counters; otherwise both read 0
module pc_fetch_ctrl
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Cnd,
  input  logic            Jump,
  input  logic            Jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            instr_done,
  input  logic            trap_clear,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic [XLEN-1:0] bad_target,
  output logic [31:0]     taken_cnt,
  output logic [31:0]     instret_cnt
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, bad_q, bad_d, target;
  logic            mis_q, mis_d, tgt_mis, retire;
  next_pc_calc #(.XLEN(XLEN)) u_npc (
    .pc        (pc_q),
    .imm       (imm),
    .rs1_val   (rs1_val),
    .jalr      (Jalr),
    .jump      (Jump),
    .cnd       (Cnd),
    .target    (target),
    .misaligned(tgt_mis)
  );
  assign retire = (state_q == EXEC) && instr_done;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    bad_d   = bad_q;
    if (state_q == FETCH && if_req_ready) state_d = EXEC;
    if (retire) begin
      state_d = tgt_mis ? TRAP : FETCH;
      pc_d    = tgt_mis ? pc_q : target;
      mis_d   = tgt_mis;
      bad_d   = tgt_mis ? target : bad_q;
    end
    if (state_q == TRAP && trap_clear) begin
      state_d = FETCH;
      pc_d    = RESET_PC;
      mis_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
    end
  end
  // rst gates the request combinationally so an outstanding fetch drops immediately
  assign if_req_valid = (state_q == FETCH) && !rst;
  assign if_addr      = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + XLEN'(INSN_BYTES);
  assign misalign     = mis_q;
  assign bad_target   = bad_q;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] taken_q, instret_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q   <= '0;
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
      taken_q   <= taken_q + {31'd0, (Jalr | Jump | Cnd) && !tgt_mis};
    end
  end
  assign taken_cnt   = taken_q;
  assign instret_cnt = instret_q;
`else
  assign taken_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-request stage directly downstream of the branch-condition unit.
- Holds the architectural PC and consumes the resolved branch condition plus jump controls when the core retires an instruction.
- Computes the next PC and issues a valid/ready fetch request to instruction memory.
- Detects misaligned control-flow targets and parks in a trap state until cleared.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on trap clear.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- Cnd  input  1  branch taken, from the branch-condition unit.
- Jump  input  1  JAL in current instruction.
- Jalr  input  1  JALR in current instruction.
- imm  input  XLEN  sign-extended immediate of current instruction.
- rs1_val  input  XLEN  rs1 operand, used for JALR.
- instr_done  input  1  current instruction retires this cycle.
- trap_clear  input  1  leave TRAP and restart at RESET_PC.
- if_req_valid  output  1  fetch request valid.
- if_req_ready  input  1  instruction memory accepts the request.
- if_addr  output  XLEN  fetch address (= pc).
- pc  output  XLEN  PC of the instruction in flight.
- pc_plus4  output  XLEN  pc+4, for the JAL/JALR link write.
- misalign  output  1  misaligned-target trap active.
- bad_target  output  XLEN  offending target captured at trap entry.
- taken_cnt  output  32  taken branches/jumps (optional feature).
- instret_cnt  output  32  retired instructions (optional feature).

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=FETCH.
  - misalign=0, bad_target=0, counters=0.
  - if_req_valid=0 while rst is high; it asserts the first cycle after rst deasserts.
- States: FETCH, EXEC, TRAP.
- FETCH:
  - if_req_valid=1, if_addr=pc.
  - Valid and address hold stable until if_req_ready=1.
  - On valid&ready, go to EXEC next cycle.
  - instr_done is ignored in FETCH.
- EXEC:
  - if_req_valid=0; wait for instr_done.
  - On instr_done, select target with priority Jalr > Jump > Cnd > sequential:
    - Jalr: (rs1_val+imm) & ~1.
    - Jump or Cnd: pc+imm.
    - Otherwise: pc+4.
  - If target[1]=1: go to TRAP, misalign=1, bad_target=target, pc unchanged.
  - Otherwise: pc<=target, go to FETCH. if_req_valid is high the cycle after instr_done (1-cycle redirect latency).
- TRAP:
  - if_req_valid=0; instr_done is ignored.
  - On trap_clear: pc<=RESET_PC, misalign<=0, go to FETCH. bad_target holds its value.
- Arithmetic: all XLEN-bit modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no flag. pc_plus4 is combinational from pc.
- Cnd is sampled only when instr_done=1 in EXEC; Cnd asserted with Jump is treated as Jump (same target).
- Reset mid-operation: rst overrides every state, including an outstanding fetch. The request drops without waiting for ready.
- trap_clear and rst in the same cycle: rst wins (identical PC result).

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- When defined:
  - instret_cnt increments on every accepted instr_done in EXEC, including trapping ones.
  - taken_cnt increments when the selected target is non-sequential and aligned.
  - Both are 32-bit wrapping counters, cleared by rst only.
- When undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Shared package core_pkg:
  - State enum {FETCH, EXEC, TRAP}.
  - XLEN default and RESET_PC default.
  - INSN_BYTES=4.
- Sub-module next_pc_calc: combinational target select and misalign detect from pc, imm, rs1_val, Jalr, Jump, Cnd.

Test Plan:
- Reset release with RESET_PC=0: if_req_valid=1, if_addr=0. Hold ready=0 for 3 cycles, then 1: address stays 0 throughout, state moves to EXEC.
- pc=0x100, imm=0x20, Cnd=1, instr_done: next fetch at 0x120, taken_cnt=1. Repeat with Cnd=0: next fetch at 0x104.
- pc=0x200, Jalr=1, Jump=1, rs1_val=0x1001, imm=0x4: Jalr wins, next fetch at 0x1004, pc_plus4=0x204.
- pc=0x300, Jump=1, imm=0x6: misalign=1, bad_target=0x306, no request. Then trap_clear: fetch at RESET_PC, misalign=0.
- pc=0xFFFF_FFFC, sequential retire: next fetch at 0x0000_0000.
- rst asserted during FETCH with ready=0: if_req_valid=0 next cycle. After release, fetch at RESET_PC and counters are 0.
